alu_seq_ctrl: RTL

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for an external ALU: accepts one request, waits the
// op-dependent settle time, captures the result and holds it until consumed.
module alu_seq_ctrl #(
   parameter int unsigned MUL_WAIT = 2,
   parameter int unsigned DIV_WAIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_sel,
   input  logic [63:0] alu_out,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_lo,
   output logic [31:0] rsp_hi,
   output logic        rsp_err,
   output logic [31:0] hi_reg,
   output logic [31:0] lo_reg
);

   // state  | meaning
   // IDLE   | ready for a request; operands captured on accept
   // SETTLE | waiting for the ALU result (counter counts down to 0)
   // RESP   | response presented, held until rsp_ready
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] cnt;
   logic [3:0] settle_n;
   logic       err_q;
   logic       reject;
   logic       accept;
   logic       capture;

   always_comb begin
      case (req_op)
         5'd2:    settle_n = 4'(MUL_WAIT);
         5'd3:    settle_n = 4'(DIV_WAIT);
         default: settle_n = 4'd1;
      endcase
   end

   assign reject = (req_op > 5'd13) || ((req_op == 5'd3) && (req_b == 32'd0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      capture   = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == 4'd0) begin
               capture = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Rejected ops take a single zero-count pass so every response lands at
   // least one edge after accept and the ALU is never waited on.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_a   <= 32'd0;
         alu_b   <= 32'd0;
         alu_sel <= 5'd0;
         cnt     <= 4'd0;
         err_q   <= 1'b0;
         rsp_lo  <= 32'd0;
         rsp_hi  <= 32'd0;
         rsp_err <= 1'b0;
         hi_reg  <= 32'd0;
         lo_reg  <= 32'd0;
      end else begin
         if (accept) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            alu_sel <= req_op;
            err_q   <= reject;
            cnt     <= reject ? 4'd0 : settle_n - 4'd1;
         end else if ((state_q == SETTLE) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end

         if (capture) begin
            if (err_q) begin
               rsp_lo  <= 32'd0;
               rsp_hi  <= 32'd0;
               rsp_err <= 1'b1;
            end else begin
               rsp_lo  <= alu_out[31:0];
               rsp_hi  <= alu_out[63:32];
               rsp_err <= 1'b0;
               if ((alu_sel == 5'd2) || (alu_sel == 5'd3)) begin
                  hi_reg <= alu_out[63:32];
                  lo_reg <= alu_out[31:0];
               end
            end
         end
      end
   end

endmodule
